// File: rtl/equalize_hist_pkg.sv
// Shared widths, sequencer states and the LUT saturation helper for the
// histogram-equalization LUT sequencer.
package equalize_hist_pkg;

    localparam int NBINS        = 256;
    localparam int ADDR_W       = 8;
    localparam int CDF_W        = 22;
    localparam int SCALE_W      = 8;
    localparam int PROD_W       = 30;
    localparam int SHIFT_W      = 5;
    localparam int FLUSH_CYCLES = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Truncating right shift of the scaled CDF, clamped to the 8-bit LUT range.
    function automatic logic [7:0] sat_lut(input logic [PROD_W-1:0] prod,
                                           input logic [SHIFT_W-1:0] sh);
        logic [PROD_W-1:0] val;
        val = prod >> sh;
        if (val > PROD_W'(255)) begin
            sat_lut = 8'hFF;
        end else begin
            sat_lut = val[7:0];
        end
    endfunction

endpackage

// File: rtl/equalize_hist_lut_mul.sv
// Combinational unsigned CDF x scale multiplier; the product register lives
// in the sequencer so this maps onto a single DSP slice.
module equalize_hist_lut_mul
    import equalize_hist_pkg::*;
(
    input  logic [CDF_W-1:0]   a,
    input  logic [SCALE_W-1:0] b,
    output logic [PROD_W-1:0]  p
);

    assign p = PROD_W'(a) * PROD_W'(b);

endmodule

// File: rtl/equalize_hist_lut_seq.sv
// Walks a completed 256-bin histogram, accumulates the CDF, scales it and
// writes the 8-bit equalization LUT. Optionally zeroes each bin after it is read.
module equalize_hist_lut_seq
    import equalize_hist_pkg::*;
(
    input  logic               ap_clk,
    input  logic               ap_rst,
    input  logic               ap_start,
    output logic               ap_done,
    output logic               ap_idle,
    output logic               ap_ready,
    input  logic [SCALE_W-1:0] scale,
    input  logic [SHIFT_W-1:0] shift,
    input  logic               clear_en,
    output logic [ADDR_W-1:0]  hist_address0,
    output logic               hist_ce0,
    input  logic [CDF_W-1:0]   hist_q0,
    output logic [ADDR_W-1:0]  hist_address1,
    output logic               hist_ce1,
    output logic               hist_we1,
    output logic [CDF_W-1:0]   hist_d1,
    output logic [ADDR_W-1:0]  lut_address0,
    output logic               lut_ce0,
    output logic               lut_we0,
    output logic [7:0]         lut_d0
);

    state_t              state_r, state_s;
    logic                start_s;
    logic [ADDR_W-1:0]   cnt_r;
    logic [1:0]          fl_cnt_r;
    logic [SCALE_W-1:0]  scale_r;
    logic [SHIFT_W-1:0]  shift_r;
    logic                clr_en_r;
    logic                rd_ce_r;
    logic                done_r;
    logic                idle_r;

    // Pipeline: stage 1 = read data returned, stage 2 = CDF valid, stage 3 = product valid.
    logic                s1_vld_r, s2_vld_r, s3_vld_r;
    logic [ADDR_W-1:0]   s1_idx_r, s2_idx_r, s3_idx_r;
    logic                clr_ce_r;
    logic [CDF_W-1:0]    cdf_r;
    logic [PROD_W-1:0]   prod_r;
    logic [PROD_W-1:0]   mul_p_s;

    equalize_hist_lut_mul u_mul (
        .a (cdf_r),
        .b (scale_r),
        .p (mul_p_s)
    );

    // Next-state decode and start qualification.
    always_comb begin
        state_s = state_r;
        start_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (ap_start) begin
                    state_s = RUN;
                    start_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == ADDR_W'(NBINS - 1)) begin
                    state_s = FLUSH;
                end else begin
                    state_s = RUN;
                end
            end
            FLUSH: begin
                if (fl_cnt_r == 2'(FLUSH_CYCLES - 1)) begin
                    state_s = DONE;
                end else begin
                    state_s = FLUSH;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Run parameters, bin/flush counters and registered handshake/read strobes.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            cnt_r    <= '0;
            fl_cnt_r <= 2'd0;
            scale_r  <= '0;
            shift_r  <= '0;
            clr_en_r <= 1'b0;
            rd_ce_r  <= 1'b0;
            done_r   <= 1'b0;
            idle_r   <= 1'b1;
        end else begin
            if (start_s) begin
                scale_r  <= scale;
                shift_r  <= shift;
                clr_en_r <= clear_en;
            end
            if (state_r == RUN) begin
                cnt_r <= cnt_r + ADDR_W'(1);
            end else begin
                cnt_r <= '0;
            end
            if (state_r == FLUSH) begin
                fl_cnt_r <= fl_cnt_r + 2'd1;
            end else begin
                fl_cnt_r <= 2'd0;
            end
            rd_ce_r <= (state_s == RUN);
            done_r  <= (state_s == DONE);
            idle_r  <= (state_s == IDLE);
        end
    end

    // CDF accumulate, scale multiply and bin-index tags travelling with the data.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            s1_vld_r <= 1'b0;
            s2_vld_r <= 1'b0;
            s3_vld_r <= 1'b0;
            s1_idx_r <= '0;
            s2_idx_r <= '0;
            s3_idx_r <= '0;
            clr_ce_r <= 1'b0;
            cdf_r    <= '0;
            prod_r   <= '0;
        end else begin
            s1_vld_r <= rd_ce_r;
            s1_idx_r <= cnt_r;
            clr_ce_r <= rd_ce_r & clr_en_r;
            if (start_s) begin
                cdf_r <= '0;
            end else if (s1_vld_r) begin
                cdf_r <= cdf_r + hist_q0;
            end
            s2_vld_r <= s1_vld_r;
            s2_idx_r <= s1_idx_r;
            if (s2_vld_r) begin
                prod_r <= mul_p_s;
            end
            s3_vld_r <= s2_vld_r;
            s3_idx_r <= s2_idx_r;
        end
    end

    assign ap_done       = done_r;
    assign ap_ready      = done_r;
    assign ap_idle       = idle_r;
    assign hist_address0 = cnt_r;
    assign hist_ce0      = rd_ce_r;
    // Clear trails the read port by one bin, so the two ports never collide.
    assign hist_address1 = s1_idx_r;
    assign hist_ce1      = clr_ce_r;
    assign hist_we1      = clr_ce_r;
    assign hist_d1       = '0;
    assign lut_address0  = s3_idx_r;
    assign lut_ce0       = s3_vld_r;
    assign lut_we0       = s3_vld_r;
    assign lut_d0        = sat_lut(prod_r, shift_r);

endmodule

// File: tb/tb_equalize_hist_lut_seq.sv
// Self-checking bench for equalize_hist_lut_seq: histogram/LUT RAM models,
// a CDF reference model, table-driven runs and hand-written corner sequences.
module tb_equalize_hist_lut_seq;

    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b1;
    logic        ap_start = 1'b0;
    logic        ap_done, ap_idle, ap_ready;
    logic [7:0]  scale = 8'd0;
    logic [4:0]  shift = 5'd0;
    logic        clear_en = 1'b0;
    logic [7:0]  hist_address0, hist_address1, lut_address0;
    logic        hist_ce0, hist_ce1, hist_we1, lut_ce0, lut_we0;
    logic [21:0] hist_q0 = 22'd0;
    logic [21:0] hist_d1;
    logic [7:0]  lut_d0;

    equalize_hist_lut_seq dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
        .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
        .scale(scale), .shift(shift), .clear_en(clear_en),
        .hist_address0(hist_address0), .hist_ce0(hist_ce0), .hist_q0(hist_q0),
        .hist_address1(hist_address1), .hist_ce1(hist_ce1), .hist_we1(hist_we1),
        .hist_d1(hist_d1),
        .lut_address0(lut_address0), .lut_ce0(lut_ce0), .lut_we0(lut_we0),
        .lut_d0(lut_d0)
    );

    always #5 ap_clk = ~ap_clk;

    logic [21:0] hist_init [256];
    logic [21:0] hist_mem  [256];
    logic [7:0]  lut_mem   [256];
    logic        load_req = 1'b0;
    int          cyc = 0;
    int          done_cnt = 0, lut_wr_cnt = 0, we1_cnt = 0;
    int          bad_d1 = 0, ready_bad = 0, collide = 0;
    int          last_done_cyc = 0, prev_done_cyc = 0;
    int          n_cmp = 0, n_fail = 0;

    // RAM models plus event counters, all sampled on the active edge.
    always @(posedge ap_clk) begin
        cyc <= cyc + 1;
        if (load_req) begin
            for (int k = 0; k < 256; k++) hist_mem[k] <= hist_init[k];
        end else begin
            if (hist_ce0) hist_q0 <= hist_mem[hist_address0];
            if (hist_ce1 && hist_we1) begin
                hist_mem[hist_address1] <= hist_d1;
                we1_cnt <= we1_cnt + 1;
                if (hist_d1 != 22'd0) bad_d1 <= bad_d1 + 1;
                if (hist_ce0 && hist_address0 == hist_address1) collide <= collide + 1;
            end
        end
        if (lut_ce0 && lut_we0) begin
            lut_mem[lut_address0] <= lut_d0;
            lut_wr_cnt <= lut_wr_cnt + 1;
        end
        if (ap_done) begin
            done_cnt      <= done_cnt + 1;
            prev_done_cyc <= last_done_cyc;
            last_done_cyc <= cyc;
        end
        if (ap_done != ap_ready) ready_bad <= ready_bad + 1;
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fill(input int pat);
        for (int k = 0; k < 256; k++) begin
            case (pat)
                0:       hist_init[k] = 22'd8100;
                1:       hist_init[k] = (k == 0) ? 22'd2073600 : 22'd0;
                2:       hist_init[k] = 22'(k);
                default: hist_init[k] = 22'($urandom_range(0, 16000));
            endcase
        end
        @(negedge ap_clk); load_req = 1'b1;
        @(negedge ap_clk); load_req = 1'b0;
    endtask

    // One complete frame; the expected LUT comes from a running-sum model.
    task automatic run_frame(input string tag, input logic [7:0] sc, input logic [4:0] sh,
                             input logic ce, input int pulse_at, input int tail);
        logic [7:0] exp_lut [256];
        longint acc, v;
        int c0, d0, w0, e0, k, bad;
        acc = 0;
        for (int i = 0; i < 256; i++) begin
            acc = acc + longint'(hist_init[i]);
            v = (acc * longint'(sc)) >> sh;
            exp_lut[i] = (v > 255) ? 8'd255 : 8'(v);
        end
        d0 = done_cnt; w0 = lut_wr_cnt; e0 = we1_cnt;
        @(negedge ap_clk);
        ap_start = 1'b1; scale = sc; shift = sh; clear_en = ce; c0 = cyc;
        @(negedge ap_clk);
        ap_start = 1'b0;
        scale = 8'($urandom); shift = 5'($urandom); clear_en = ~ce;
        k = 1;
        while (done_cnt == d0 && k < 400) begin
            ap_start = (pulse_at > 0 && k == pulse_at) ? 1'b1 : 1'b0;
            @(negedge ap_clk);
            k++;
        end
        ap_start = 1'b0;
        check({tag, "_done_seen"}, (done_cnt != d0) ? 1 : 0, 1);
        check({tag, "_done_cycle"}, last_done_cyc - c0, 260);
        repeat (tail) @(negedge ap_clk);
        check({tag, "_done_pulses"}, done_cnt - d0, 1);
        check({tag, "_lut_writes"}, lut_wr_cnt - w0, 256);
        bad = 0;
        for (int i = 0; i < 256; i++) if (lut_mem[i] !== exp_lut[i]) bad++;
        check({tag, "_lut_bad_entries"}, bad, 0);
        bad = 0;
        for (int i = 0; i < 256; i++)
            if (hist_mem[i] !== (ce ? 22'd0 : hist_init[i])) bad++;
        check({tag, "_hist_bad_bins"}, bad, 0);
        check({tag, "_clear_writes"}, we1_cnt - e0, ce ? 256 : 0);
        check({tag, "_idle_after"}, ap_idle, 1);
    endtask

    typedef struct {
        string      name;
        int         pat;
        logic [7:0] sc;
        logic [4:0] sh;
        logic       ce;
        int         i0, x0, i1, x1, i2, x2;
    } vec_t;

    vec_t vt [5];

    initial begin
        int c0, d0, w0, k;
        vt[0] = '{"uniform",  0, 8'd129, 5'd20, 1'b0,   0,   0, 127, 127, 255, 255};
        vt[1] = '{"bin0_sat", 1, 8'd255, 5'd20, 1'b1,   0, 255, 128, 255, 255, 255};
        vt[2] = '{"ramp_sh0", 2, 8'd1,   5'd0,  1'b1,   3,   6,  22, 253,  23, 255};
        vt[3] = '{"scale0",   3, 8'd0,   5'd7,  1'b0,   0,   0, 100,   0, 255,   0};
        vt[4] = '{"ramp_sh4", 2, 8'd1,   5'd4,  1'b0,  10,   3,  20,  13,  60, 114};

        repeat (3) @(negedge ap_clk);
        check("rst_idle", ap_idle, 1);
        check("rst_done", ap_done, 0);
        check("rst_ready", ap_ready, 0);
        check("rst_enables", {hist_ce0, hist_ce1, hist_we1, lut_ce0, lut_we0}, 0);
        check("rst_addr_data", {hist_address0, hist_address1, lut_address0, lut_d0}, 0);
        ap_rst = 1'b0;
        repeat (2) @(negedge ap_clk);

        for (int t = 0; t < 5; t++) begin
            fill(vt[t].pat);
            run_frame(vt[t].name, vt[t].sc, vt[t].sh, vt[t].ce, 0, 3);
            check({vt[t].name, "_probe0"}, lut_mem[vt[t].i0], vt[t].x0);
            check({vt[t].name, "_probe1"}, lut_mem[vt[t].i1], vt[t].x1);
            check({vt[t].name, "_probe2"}, lut_mem[vt[t].i2], vt[t].x2);
        end

        for (int t = 0; t < 4; t++) begin
            fill(3);
            run_frame("random", 8'($urandom), 5'($urandom_range(0, 29)),
                      1'($urandom), 0, 3);
        end

        // Reset in the middle of a run.
        fill(2);
        d0 = done_cnt;
        @(negedge ap_clk);
        ap_start = 1'b1; scale = 8'd1; shift = 5'd0; clear_en = 1'b0; c0 = cyc;
        @(negedge ap_clk);
        ap_start = 1'b0;
        while (cyc < c0 + 100) @(negedge ap_clk);
        ap_rst = 1'b1;
        @(negedge ap_clk);
        check("midrst_idle", ap_idle, 1);
        check("midrst_enables", {hist_ce0, hist_ce1, lut_ce0, lut_we0}, 0);
        w0 = lut_wr_cnt;
        ap_rst = 1'b0;
        repeat (30) @(negedge ap_clk);
        check("midrst_no_writes", lut_wr_cnt - w0, 0);
        check("midrst_no_done", done_cnt - d0, 0);
        run_frame("after_rst", 8'd3, 5'd2, 1'b0, 0, 3);

        // ap_start held high: back-to-back runs.
        fill(3);
        d0 = done_cnt;
        @(negedge ap_clk);
        ap_start = 1'b1; scale = 8'd200; shift = 5'd15; clear_en = 1'b0; c0 = cyc;
        k = 0;
        while (done_cnt < d0 + 2 && k < 800) begin
            @(negedge ap_clk);
            k++;
        end
        ap_start = 1'b0;
        check("held_two_dones", done_cnt - d0, 2);
        check("held_first_done", prev_done_cyc - c0, 260);
        check("held_spacing", last_done_cyc - prev_done_cyc, 261);
        repeat (300) @(negedge ap_clk);
        check("held_no_third", done_cnt - d0, 2);

        // ap_start pulsed during RUN must be ignored.
        fill(3);
        run_frame("pulse_in_run", 8'd77, 5'd12, 1'b0, 50, 300);

        check("ready_matches_done", ready_bad, 0);
        check("clear_data_zero", bad_d1, 0);
        check("port_collisions", collide, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
